// File: rtl/cpu_pkg.sv
// Shared widths, opcode constants, decode helpers and the per-stage pipeline payload
// used by the dual-lane execution core.
package cpu_pkg;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 9;
    localparam int unsigned PW    = 8;
    localparam int unsigned RAW   = 3;
    localparam int unsigned NREG  = 8;
    localparam int unsigned NLANE = 2;
    localparam int unsigned NRD   = 4;

    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_ALU = 3'b101;
    localparam logic [2:0] OP_LDR = 3'b011;
    localparam logic [2:0] OP_STR = 3'b100;

    localparam logic [1:0] SUB_MOV_REG = 2'b00;
    localparam logic [1:0] SUB_MOV_IMM = 2'b10;
    localparam logic [1:0] SUB_ADD     = 2'b00;
    localparam logic [1:0] SUB_CMP     = 2'b01;
    localparam logic [1:0] SUB_AND     = 2'b10;
    localparam logic [1:0] SUB_MVN     = 2'b11;
    localparam logic [1:0] SUB_MEM     = 2'b00;

    localparam logic [1:0] SH_LSL = 2'b01;
    localparam logic [1:0] SH_LSR = 2'b10;
    localparam logic [1:0] SH_ASR = 2'b11;

    typedef struct packed {
        logic            valid;
        logic [DW-1:0]   ir;
        logic [PW-1:0]   pc;
        logic [DW-1:0]   a;
        logic [DW-1:0]   b;
        logic [DW-1:0]   result;
        logic            wb_en;
        logic [RAW-1:0]  rd;
    } stage_t;

    function automatic logic [DW-1:0] shift_op(input logic [1:0] sh, input logic [DW-1:0] v);
        case (sh)
            SH_LSL:  return {v[DW-2:0], 1'b0};
            SH_LSR:  return {1'b0, v[DW-1:1]};
            SH_ASR:  return {v[DW-1], v[DW-1:1]};
            default: return v;
        endcase
    endfunction

    function automatic logic [DW-1:0] sext8(input logic [7:0] v);
        return {{(DW-8){v[7]}}, v};
    endfunction

    function automatic logic [DW-1:0] sext5(input logic [4:0] v);
        return {{(DW-5){v[4]}}, v};
    endfunction

    function automatic logic is_ldr(input logic [DW-1:0] ir);
        return (ir[15:13] == OP_LDR) && (ir[12:11] == SUB_MEM);
    endfunction

    function automatic logic is_str(input logic [DW-1:0] ir);
        return (ir[15:13] == OP_STR) && (ir[12:11] == SUB_MEM);
    endfunction

    function automatic logic writes_reg(input logic [DW-1:0] ir);
        case (ir[15:13])
            OP_MOV:  return (ir[12:11] == SUB_MOV_IMM) || (ir[12:11] == SUB_MOV_REG);
            OP_ALU:  return ir[12:11] != SUB_CMP;
            OP_LDR:  return ir[12:11] == SUB_MEM;
            default: return 1'b0;
        endcase
    endfunction

    // MOV immediate targets the Rn field; everything else targets Rd
    function automatic logic [RAW-1:0] dest_reg(input logic [DW-1:0] ir);
        if ((ir[15:13] == OP_MOV) && (ir[12:11] == SUB_MOV_IMM)) begin
            return ir[10:8];
        end
        return ir[7:5];
    endfunction

endpackage

// File: rtl/regfile_4r2w.sv
// 8x16 register file: four combinational read ports, two write ports where
// port 1 (lane p1) wins when both write the same register.
module regfile_4r2w
    import cpu_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NRD-1:0][RAW-1:0]   raddr,
    output logic [NRD-1:0][DW-1:0]    rdata_c,
    input  logic [1:0]                we,
    input  logic [1:0][RAW-1:0]       waddr,
    input  logic [1:0][DW-1:0]        wdata
);

    logic [NREG-1:0][DW-1:0] regs_q;
    logic [NREG-1:0][DW-1:0] regs_d;

    // Port 1 applied last so it overrides port 0 on a collision
    always_comb begin
        regs_d = regs_q;
        if (we[0]) begin
            regs_d[waddr[0]] = wdata[0];
        end
        if (we[1]) begin
            regs_d[waddr[1]] = wdata[1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        assign rdata_c[i] = regs_q[raddr[i]];
    end

endmodule

// File: rtl/dual_issue_cpu.sv
// Two-lane in-order 16-bit core, ID -> EX -> MEM -> WB per lane, sharing one register
// file; no forwarding or interlock, so consumers closer than four issues see stale data.
module dual_issue_cpu
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   p0_IR_in,
    input  logic [DW-1:0]   p1_IR_in,
    input  logic [PW-1:0]   p0_PC_in,
    input  logic [PW-1:0]   p1_PC_in,
    input  logic [DW-1:0]   p0_DM_rdata,
    input  logic [DW-1:0]   p1_DM_rdata,
    output logic [AW-1:0]   p0_DM_maddr,
    output logic [AW-1:0]   p1_DM_maddr,
    output logic [DW-1:0]   p0_DM_wdata,
    output logic [DW-1:0]   p1_DM_wdata,
    output logic            p0_DM_write_mem,
    output logic            p1_DM_write_mem
);

    logic [NLANE-1:0][DW-1:0]  ir_in;
    logic [NLANE-1:0][PW-1:0]  pc_in;
    logic [NLANE-1:0][DW-1:0]  rdata_in;
    logic [NLANE-1:0][AW-1:0]  dm_maddr;
    logic [NLANE-1:0][DW-1:0]  dm_wdata;
    logic [NLANE-1:0]          dm_we;

    logic [NRD-1:0][RAW-1:0]   rf_raddr;
    logic [NRD-1:0][DW-1:0]    rf_rdata;
    logic [NLANE-1:0]          rf_we;
    logic [NLANE-1:0][RAW-1:0] rf_waddr;
    logic [NLANE-1:0][DW-1:0]  rf_wdata;

    assign ir_in    = {p1_IR_in, p0_IR_in};
    assign pc_in    = {p1_PC_in, p0_PC_in};
    assign rdata_in = {p1_DM_rdata, p0_DM_rdata};

    regfile_4r2w u_regfile (
        .clk     (clk),
        .rst     (rst),
        .raddr   (rf_raddr),
        .rdata_c (rf_rdata),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata)
    );

    for (genvar l = 0; l < NLANE; l++) begin : g_lane
        stage_t        id_q, id_d, ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
        logic          mem_we_q, mem_we_d;
        logic [2:0]    flags_q, flags_d;
        logic [DW-1:0] sh_c, diff_c, result_c;
        logic          unused_sink;

        // Store data comes from Rd, so the second read port switches source for STR
        assign rf_raddr[2*l]   = id_q.ir[10:8];
        assign rf_raddr[2*l+1] = is_str(id_q.ir) ? id_q.ir[7:5] : id_q.ir[2:0];

        always_comb begin
            id_d       = '0;
            id_d.valid = 1'b1;
            id_d.ir    = ir_in[l];
            id_d.pc    = pc_in[l];

            ex_d       = id_q;
            ex_d.a     = rf_rdata[2*l];
            ex_d.b     = rf_rdata[2*l+1];
            ex_d.wb_en = writes_reg(id_q.ir);
            ex_d.rd    = dest_reg(id_q.ir);
        end

        always_comb begin
            sh_c     = shift_op(ex_q.ir[4:3], ex_q.b);
            diff_c   = ex_q.a - sh_c;
            result_c = ex_q.a + sext5(ex_q.ir[4:0]);
            case (ex_q.ir[15:13])
                OP_MOV: result_c = (ex_q.ir[12:11] == SUB_MOV_IMM) ? sext8(ex_q.ir[7:0]) : sh_c;
                OP_ALU: begin
                    case (ex_q.ir[12:11])
                        SUB_ADD: result_c = ex_q.a + sh_c;
                        SUB_AND: result_c = ex_q.a & sh_c;
                        SUB_MVN: result_c = ~sh_c;
                        default: result_c = diff_c;
                    endcase
                end
                default: ;
            endcase

            mem_d        = ex_q;
            mem_d.result = result_c;
            mem_we_d     = ex_q.valid && is_str(ex_q.ir);

            flags_d = flags_q;
            if (ex_q.valid && (ex_q.ir[15:13] == OP_ALU) && (ex_q.ir[12:11] == SUB_CMP)) begin
                flags_d = {(diff_c == '0), diff_c[DW-1],
                           (ex_q.a[DW-1] != sh_c[DW-1]) && (diff_c[DW-1] != ex_q.a[DW-1])};
            end
        end

        always_comb begin
            wb_d = mem_q;
            if (is_ldr(mem_q.ir)) begin
                wb_d.result = rdata_in[l];
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                id_q     <= '0;
                ex_q     <= '0;
                mem_q    <= '0;
                wb_q     <= '0;
                mem_we_q <= 1'b0;
                flags_q  <= '0;
            end else begin
                id_q     <= id_d;
                ex_q     <= ex_d;
                mem_q    <= mem_d;
                wb_q     <= wb_d;
                mem_we_q <= mem_we_d;
                flags_q  <= flags_d;
            end
        end

        assign rf_we[l]    = wb_q.valid && wb_q.wb_en;
        assign rf_waddr[l] = wb_q.rd;
        assign rf_wdata[l] = wb_q.result;

        assign dm_maddr[l] = mem_q.result[AW-1:0];
        assign dm_wdata[l] = mem_q.b;
        assign dm_we[l]    = mem_we_q;

        // PC copies and flags have no consumer inside the core
        assign unused_sink = ^{id_q, ex_q, mem_q, wb_q, flags_q};
    end

    assign p0_DM_maddr     = dm_maddr[0];
    assign p1_DM_maddr     = dm_maddr[1];
    assign p0_DM_wdata     = dm_wdata[0];
    assign p1_DM_wdata     = dm_wdata[1];
    assign p0_DM_write_mem = dm_we[0];
    assign p1_DM_write_mem = dm_we[1];

endmodule

// File: tb/tb_dual_issue_cpu.sv
// Bench for dual_issue_cpu: directed and random instruction pairs checked against an
// architectural model with fixed issue-to-memory and issue-to-writeback latencies.
module tb_dual_issue_cpu;

    localparam int MAXC = 4096;
    localparam logic [15:0] NOP = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] p0_ir, p1_ir;
    logic [7:0]  p0_pc, p1_pc;
    logic [15:0] p0_rdata, p1_rdata;
    logic [8:0]  p0_maddr, p1_maddr;
    logic [15:0] p0_wdata, p1_wdata;
    logic        p0_we, p1_we;

    logic [15:0] regs [8];
    bit          wr_en    [2][MAXC];
    logic [2:0]  wr_rd    [2][MAXC];
    logic [15:0] wr_val   [2][MAXC];
    int          mem_kind [2][MAXC];
    logic [8:0]  mem_addr [2][MAXC];
    logic [15:0] mem_data [2][MAXC];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] ram_word(input int lane, input logic [8:0] a);
        return (16'(a) * 16'h0D3B) ^ ((lane == 0) ? 16'h1234 : 16'hBEEF);
    endfunction

    assign p0_rdata = ram_word(0, p0_maddr);
    assign p1_rdata = ram_word(1, p1_maddr);

    dual_issue_cpu dut (
        .clk             (clk),
        .rst             (rst),
        .p0_IR_in        (p0_ir),
        .p1_IR_in        (p1_ir),
        .p0_PC_in        (p0_pc),
        .p1_PC_in        (p1_pc),
        .p0_DM_rdata     (p0_rdata),
        .p1_DM_rdata     (p1_rdata),
        .p0_DM_maddr     (p0_maddr),
        .p1_DM_maddr     (p1_maddr),
        .p0_DM_wdata     (p0_wdata),
        .p1_DM_wdata     (p1_wdata),
        .p0_DM_write_mem (p0_we),
        .p1_DM_write_mem (p1_we)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] shv(input logic [1:0] s, input logic [15:0] v);
        case (s)
            2'd1:    return v << 1;
            2'd2:    return v >> 1;
            2'd3:    return 16'($signed(v) >>> 1);
            default: return v;
        endcase
    endfunction

    task automatic post_write(input int l, input logic [2:0] r, input logic [15:0] v);
        wr_en[l][cyc+4]  = 1'b1;
        wr_rd[l][cyc+4]  = r;
        wr_val[l][cyc+4] = v;
    endtask

    // Architectural effect of one instruction issued on lane l at edge cyc
    task automatic model_issue(input int l, input logic [15:0] ir);
        logic [2:0]  op, rn, rd, rm;
        logic [1:0]  sub;
        logic [15:0] sm, ea;
        op  = ir[15:13];
        sub = ir[12:11];
        rn  = ir[10:8];
        rd  = ir[7:5];
        rm  = ir[2:0];
        sm  = shv(ir[4:3], regs[rm]);
        ea  = regs[rn] + 16'($signed(ir[4:0]));
        if (op == 3'b110 && sub == 2'b10) begin
            post_write(l, rn, 16'($signed(ir[7:0])));
        end else if (op == 3'b110 && sub == 2'b00) begin
            post_write(l, rd, sm);
        end else if (op == 3'b101) begin
            if (sub == 2'b00) post_write(l, rd, regs[rn] + sm);
            if (sub == 2'b10) post_write(l, rd, regs[rn] & sm);
            if (sub == 2'b11) post_write(l, rd, ~sm);
        end else if (op == 3'b011 && sub == 2'b00) begin
            mem_kind[l][cyc+2] = 1;
            mem_addr[l][cyc+2] = ea[8:0];
            post_write(l, rd, ram_word(l, ea[8:0]));
        end else if (op == 3'b100 && sub == 2'b00) begin
            mem_kind[l][cyc+2] = 2;
            mem_addr[l][cyc+2] = ea[8:0];
            mem_data[l][cyc+2] = regs[rd];
        end
    endtask

    task automatic check_mem(input int c);
        logic       we_g;
        logic [8:0] a_g;
        logic [15:0] d_g;
        for (int l = 0; l < 2; l++) begin
            we_g = (l == 0) ? p0_we : p1_we;
            a_g  = (l == 0) ? p0_maddr : p1_maddr;
            d_g  = (l == 0) ? p0_wdata : p1_wdata;
            check_eq($sformatf("p%0d_write_mem", l), 16'(we_g), 16'(mem_kind[l][c] == 2));
            if (mem_kind[l][c] != 0) check_eq($sformatf("p%0d_maddr", l), 16'(a_g), 16'(mem_addr[l][c]));
            if (mem_kind[l][c] == 2) check_eq($sformatf("p%0d_wdata", l), d_g, mem_data[l][c]);
        end
    endtask

    task automatic step(input logic [15:0] i0, input logic [15:0] i1);
        p0_ir = i0;
        p1_ir = i1;
        p0_pc = 8'($urandom);
        p1_pc = 8'($urandom);
        @(posedge clk);
        cyc++;
        for (int l = 0; l < 2; l++) begin
            if (wr_en[l][cyc]) regs[wr_rd[l][cyc]] = wr_val[l][cyc];
            wr_en[l][cyc] = 1'b0;
        end
        model_issue(0, i0);
        model_issue(1, i1);
        @(negedge clk);
        check_mem(cyc);
    endtask

    task automatic flush(input int n);
        repeat (n) step(NOP, NOP);
    endtask

    // Expose a register on lane 0's store port two edges after issuing STR Rr,[Rr,#0]
    task automatic peek_reg(input logic [2:0] r, input logic [15:0] expv);
        step({3'b100, 2'b00, r, r, 5'd0}, NOP);
        step(NOP, NOP);
        step(NOP, NOP);
        check_eq($sformatf("R%0d", r), p0_wdata, expv);
    endtask

    task automatic do_reset(input int edges);
        #2 rst = 1'b0;
        #1;
        check_eq("rst_p0_maddr", 16'(p0_maddr), 16'h0);
        check_eq("rst_p1_maddr", 16'(p1_maddr), 16'h0);
        check_eq("rst_p0_wdata", p0_wdata, 16'h0);
        check_eq("rst_p1_wdata", p1_wdata, 16'h0);
        check_eq("rst_p0_we", 16'(p0_we), 16'h0);
        check_eq("rst_p1_we", 16'(p1_we), 16'h0);
        for (int r = 0; r < 8; r++) regs[r] = '0;
        for (int c = cyc + 1; c <= cyc + 6; c++) begin
            for (int l = 0; l < 2; l++) begin
                wr_en[l][c]    = 1'b0;
                mem_kind[l][c] = 0;
            end
        end
        repeat (edges) begin
            p0_ir = 16'($urandom);
            p1_ir = 16'($urandom);
            @(posedge clk);
            cyc++;
            @(negedge clk);
            check_eq("rst_hold_p0_we", 16'(p0_we), 16'h0);
            check_eq("rst_hold_p1_we", 16'(p1_we), 16'h0);
        end
        rst = 1'b1;
    endtask

    function automatic logic [15:0] rand_ir();
        case ($urandom_range(0, 7))
            0, 1:    return {3'b110, 2'b10, 3'($urandom), 8'($urandom)};
            2:       return {3'b110, 2'b00, 11'($urandom)};
            3, 4:    return {3'b101, 13'($urandom)};
            5:       return {3'b011, 2'b00, 11'($urandom)};
            6:       return {3'b100, 2'b00, 11'($urandom)};
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        rst   = 1'b1;
        p0_ir = NOP;
        p1_ir = NOP;
        p0_pc = '0;
        p1_pc = '0;
        for (int r = 0; r < 8; r++) regs[r] = '0;
        do_reset(3);

        // MOV pair re-issued, then dual ADD with shifted operand
        repeat (9) step(16'hD002, 16'hD102);
        step(16'hA168, 16'hA188);
        flush(4);
        peek_reg(3'd3, 16'h0006);
        peek_reg(3'd4, 16'h0006);

        // MVN of all-ones, then arithmetic and logical right shift of a negative value
        step(16'hD2FF, NOP);
        flush(4);
        step(16'hB8A2, NOP);
        flush(4);
        peek_reg(3'd5, 16'h0000);
        step(16'hD280, NOP);
        flush(4);
        step(16'hC0DA, 16'hC0F2);
        flush(4);
        peek_reg(3'd6, 16'hFFC0);
        peek_reg(3'd7, 16'h7FC0);

        // Store R3 to R0+3, then load from R0-2 (address 0)
        step(16'hD002, 16'hD306);
        flush(4);
        step(16'h8063, NOP);
        step(NOP, NOP);
        step(NOP, NOP);
        check_eq("str_maddr", 16'(p0_maddr), 16'h0005);
        check_eq("str_wdata", p0_wdata, 16'h0006);
        check_eq("str_we", 16'(p0_we), 16'h0001);
        step(NOP, NOP);
        check_eq("str_we_single", 16'(p0_we), 16'h0000);
        step(16'h603E, NOP);
        flush(4);
        peek_reg(3'd1, 16'h1234);

        // Same destination on both lanes: p1 wins
        step(16'hD701, 16'hD709);
        flush(4);
        peek_reg(3'd7, 16'h0009);

        // Hazard: consumer one issue behind reads stale R1, four behind reads new R1
        step(16'hD000, 16'hD105);
        flush(4);
        step(16'hD107, NOP);
        step(16'hA140, NOP);
        flush(4);
        peek_reg(3'd2, 16'h0005);
        step(16'hD109, NOP);
        flush(3);
        step(16'hA140, NOP);
        flush(4);
        peek_reg(3'd2, 16'h0009);

        for (int i = 0; i < 1200; i++) step(rand_ir(), rand_ir());

        // Mid-run reset drops everything in flight
        for (int i = 0; i < 3; i++) step({3'b110, 2'b10, 3'($urandom), 8'($urandom | 1)}, rand_ir());
        do_reset(2);
        for (int r = 0; r < 8; r++) peek_reg(3'(r), 16'h0000);

        for (int i = 0; i < 300; i++) step(rand_ir(), rand_ir());
        flush(4);
        for (int r = 0; r < 8; r++) peek_reg(3'(r), regs[r]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
